register_file_scoreboard_param: RTL
===================================

// Module: register_file_scoreboard_param
// PURPOSE
//  Parametrised multi-read-port register file with a per-register busy scoreboard, for the pipelined CPU.
//  The top address (2^AW-1) is not stored; reads of it return pc_plus8, and writes to it are ignored.
//  Per-register busy bits track in-flight destination writes and flag read hazards to issue logic.
//  Optional write-to-read bypass.
// PARAMETERS
//  W        32  data width in bits
//  AW       4   address width; stored registers = 2^AW-1 (R0..R(2^AW-2))
//  NR       2   number of combinational read ports
//  BYPASS   1   1: a same-cycle write to a read address forwards wd to rd; 0: no forwarding
// PORTS
//  clk        in   1       rising-edge clock
//  reset      in   1       synchronous, active-high; clears all registers and busy bits
//  we         in   1       write enable (writeback stage)
//  wa         in   AW      write address
//  wd         in   W       write data
//  ra         in   NR*AW   read addresses, port p at [p*AW +: AW]
//  rd         out  NR*W    read data, port p at [p*W +: W]
//  hazard     out  NR      port p: register ra[p] has an outstanding reservation
//  pc_plus8   in   W       value returned for reads of the top address
//  rsv_valid  in   1       request to reserve register rsv_addr as pending destination (issue stage)
//  rsv_addr   in   AW      register to reserve
//  rsv_ready  out  1       reservation accepted this cycle (with rsv_valid)
//  busy_vec   out  2^AW    busy bit per address; top bit is constant 0 (testbench/debug)
// BEHAVIOUR
//  Storage
//   - Write: at posedge clk, if we && !reset && wa!=top, then rf[wa] <= wd. Write latency is 1 cycle.
//   - Writes to the top address change nothing: no data change and no busy clear.
//  Reads (combinational, per port p)
//   - ra[p]==top                               -> pc_plus8
//   - else BYPASS && we && wa==ra[p]           -> wd
//   - else                                     -> rf[ra[p]]
//  Scoreboard
//   - busy[i] set: rsv_valid && rsv_ready && rsv_addr==i (i != top)
//   - busy[i] clear: we && wa==i
//   - Set and clear on the same i in the same cycle: set wins, so busy[i] stays 1 (a new writer is pending).
//   - rsv_ready = (rsv_addr==top) | ~busy[rsv_addr] | (we && wa==rsv_addr)
//   - At most one outstanding writer per register; a refused reservation changes no state.
//   - rsv_valid with rsv_addr==top: rsv_ready=1; no bit is set (PC writes are handled outside).
//   - hazard[p] = busy[ra[p]] & ~(BYPASS & we & wa==ra[p]); it is always 0 for the top address.
//   - A write to a non-busy register is legal: data is written and busy stays 0.
//  Reset
//   - At posedge clk with reset=1: all rf = 0 and all busy = 0. Reset has priority over we and rsv_valid.
//   - During and after reset: rd = 0, or pc_plus8 / wd per the read rules; hazard = 0; busy_vec = 0.
//   - rsv_ready during reset: rsv_ready=1, but nothing is recorded.
//   - Reset mid-operation drops all reservations; any in-flight writeback after reset writes data only.
//  Widths: no arithmetic inside the block; rd is W bits; no sign or width extension.
// TESTING
//  1 reset; write R3=0xDEADBEEF; next cycle read ra0=3 -> rd0=0xDEADBEEF; ra1=15 with pc_plus8=0x108 -> rd1=0x108.
//  2 BYPASS=1: we=1, wa=5, wd=0x1234, ra0=5 in the same cycle -> rd0=0x1234 that cycle, hazard0=0.
//    BYPASS=0: same stimulus -> rd0 = old value.
//  3 Reserve R7 (rsv_ready=1); next cycle ra0=7 -> hazard0=1; reserving R7 again -> rsv_ready=0.
//    Then we=1, wa=7 -> busy_vec[7]=0 next cycle.
//  4 R2 busy; same cycle we=1, wa=2 and rsv_valid=1, rsv_addr=2 -> rsv_ready=1; busy_vec[2]=1 next cycle.
//  5 Write wa=15, wd=0xFFFFFFFF and reserve rsv_addr=15 -> no rf change; busy_vec=0; rd for ra=15 still = pc_plus8.
//  6 R1=0x55, R4 busy; assert reset one cycle with we=1, wa=1 -> R1=0, busy_vec=0, hazard=0.

Source files
------------

// File: rtl/register_file_scoreboard_param.sv
// Multi-read-port register file with a per-register busy scoreboard.
// The top address is not stored: reads of it return pc_plus8 and writes to it are dropped.
// Busy bits mark registers with an outstanding writer so issue logic can detect read hazards.
module register_file_scoreboard_param #(
    parameter int unsigned W      = 32,
    parameter int unsigned AW     = 4,
    parameter int unsigned NR     = 2,
    parameter bit          BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [AW-1:0]     wa,
    input  logic [W-1:0]      wd,
    input  logic [NR*AW-1:0]  ra,
    output logic [NR*W-1:0]   rd,
    output logic [NR-1:0]     hazard,
    input  logic [W-1:0]      pc_plus8,
    input  logic              rsv_valid,
    input  logic [AW-1:0]     rsv_addr,
    output logic              rsv_ready,
    output logic [2**AW-1:0]  busy_vec
);

    localparam int unsigned NumRegs = 2 ** AW;
    localparam logic [AW-1:0] TopAddr = AW'(NumRegs - 1);

    // The top entry exists only so every address indexes in range; it is never written.
    logic [W-1:0]       rf_q [NumRegs];
    logic [NumRegs-1:0] busy_q;
    logic [NumRegs-1:0] busy_d;
    logic [NumRegs-1:0] wr_hit;
    logic [NumRegs-1:0] rsv_hit;
    logic [AW-1:0]      ra_p;
    logic               byp_p;

    // Reservation is accepted unless the register already has a pending writer that is
    // not retiring this cycle. During reset it is acknowledged but nothing is recorded.
    assign rsv_ready = reset
                     | (rsv_addr == TopAddr)
                     | ~busy_q[rsv_addr]
                     | (we && (wa == rsv_addr));

    // Decode per-register write and reservation strobes; the top address never matches.
    always_comb begin
        wr_hit  = '0;
        rsv_hit = '0;
        for (int i = 0; i < NumRegs - 1; i++) begin
            wr_hit[i]  = we && (wa == AW'(i));
            rsv_hit[i] = rsv_valid && rsv_ready && (rsv_addr == AW'(i));
        end
    end

    // Next busy state: a new reservation wins over a retiring write to the same register.
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < NumRegs - 1; i++) begin
            if (rsv_hit[i]) begin
                busy_d[i] = 1'b1;
            end else if (wr_hit[i]) begin
                busy_d[i] = 1'b0;
            end
        end
        busy_d[NumRegs-1] = 1'b0;
    end

    // Scoreboard register; reset drops every reservation.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Register storage with one-cycle write latency; reset has priority over writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NumRegs; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NumRegs - 1; i++) begin
                if (wr_hit[i]) begin
                    rf_q[i] <= wd;
                end
            end
        end
    end

    // Combinational read ports with optional same-cycle forwarding and hazard flags.
    always_comb begin
        rd     = '0;
        hazard = '0;
        ra_p   = '0;
        byp_p  = 1'b0;
        for (int p = 0; p < NR; p++) begin
            ra_p  = ra[p*AW +: AW];
            byp_p = BYPASS && we && (wa == ra_p);
            if (ra_p == TopAddr) begin
                rd[p*W +: W] = pc_plus8;
            end else if (byp_p) begin
                rd[p*W +: W] = wd;
            end else if (reset) begin
                // Storage is being cleared, so present its post-reset value.
                rd[p*W +: W] = '0;
            end else begin
                rd[p*W +: W] = rf_q[ra_p];
            end
            hazard[p] = !reset && (ra_p != TopAddr) && busy_q[ra_p] && !byp_p;
        end
    end

    assign busy_vec = reset ? '0 : busy_q;

endmodule
